// File: rtl/stage_mem1_pkg.sv
// stage_mem1_pkg: shared types and helpers for the MEM1 pipeline stage
//   memsize_t    : access width (BYTE/HALF/WORD)
//   ecause_t     : exception cause codes raised by the stage
//   mem1_state_t : bus sequencing states
//   misaligned() : alignment rule shared by the stage and its lane aligner
package stage_mem1_pkg;
    typedef enum logic [1:0] {BYTE = 2'd0, HALF = 2'd1, WORD = 2'd2} memsize_t;
    typedef enum logic [3:0] {EC_NONE = 4'd0, LMISALIGNED = 4'd4, SMISALIGNED = 4'd6} ecause_t;
    typedef enum logic [1:0] {IDLE, REQ, DONE} mem1_state_t;
    function automatic logic misaligned(memsize_t size, logic [1:0] a);
        return (size == HALF && a[0]) || (size == WORD && a != 2'd0);
    endfunction
endpackage

// File: rtl/mem1_align.sv
// mem1_align: combinational byte-lane alignment for loads and stores
//   size/uns/a : access width, zero-extend flag, address low bits
//   rdata      : raw bus read word -> ld_data (extracted, extended)
//   wdata      : store data        -> st_data (replicated across lanes), be
//   misal      : access is misaligned for its width
module mem1_align
    import stage_mem1_pkg::*;
(
    input  memsize_t    size,
    input  logic        uns,
    input  logic [1:0]  a,
    input  logic [31:0] rdata,
    input  logic [31:0] wdata,
    output logic [31:0] ld_data,
    output logic [31:0] st_data,
    output logic [3:0]  be,
    output logic        misal
);
    logic [7:0]  b;
    logic [15:0] h;
    assign b       = rdata[{a, 3'b000} +: 8];
    assign h       = rdata[{a[1], 4'b0000} +: 16];
    assign ld_data = (size == BYTE) ? {{24{~uns & b[7]}}, b} :
                     (size == HALF) ? {{16{~uns & h[15]}}, h} : rdata;
    assign st_data = (size == BYTE) ? {4{wdata[7:0]}} :
                     (size == HALF) ? {2{wdata[15:0]}} : wdata;
    assign be      = (size == BYTE) ? 4'b0001 << a :
                     (size == HALF) ? (a[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    assign misal   = misaligned(size, a);
endmodule

// File: rtl/stage_mem1.sv
// stage_mem1: MEM1 pipeline stage, issues data-bus accesses and forwards results to writeback
//   clk_core, reset (sync, active-high)
//   ex_*    : execute-stage entry, captured when neither this stage nor writeback stalls
//   dbus_*  : single-outstanding request/ack data bus
//   mem1_*  : writeback result, stall/busy, misalignment exception and pass-through fields
//   wb_stall: freezes the stage register; csr_kill: drops the held entry
module stage_mem1
    import stage_mem1_pkg::*;
(
    input  logic        clk_core,
    input  logic        reset,
    input  logic        ex_valid,
    input  logic        ex_mem_en,
    input  logic        ex_mem_we,
    input  memsize_t    ex_mem_size,
    input  logic        ex_mem_unsigned,
    input  logic [31:0] ex_addr,
    input  logic [31:0] ex_data,
    input  logic [4:0]  ex_wb_reg,
    input  logic [31:2] ex_pc,
    input  logic        ex_flush,
    output logic        dbus_req,
    output logic        dbus_we,
    output logic [31:2] dbus_addr,
    output logic [3:0]  dbus_be,
    output logic [31:0] dbus_wdata,
    input  logic        dbus_ack,
    input  logic [31:0] dbus_rdata,
    output logic        mem1_valid_wb,
    output logic        mem1_stall,
    output logic        mem1_busy,
    output logic        mem1_exc,
    output ecause_t     mem1_exc_cause,
    output logic        mem1_flush,
    output logic [31:2] mem1_pc,
    output logic [4:0]  mem1_wb_reg,
    output logic [31:0] mem1_dout,
    input  logic        wb_stall,
    input  logic        csr_kill
);
    mem1_state_t state, state_nx;
    logic        v, kil, e_mem, e_we, e_uns, e_flush, misal, exc, cap, ack;
    memsize_t    e_size;
    logic [31:0] e_addr, e_data, ld_q, ld_data, st_data;
    logic [4:0]  e_wb;
    logic [31:2] e_pc;
    logic [3:0]  be;

    mem1_align u_align (
        .size    (e_size),
        .uns     (e_uns),
        .a       (e_addr[1:0]),
        .rdata   (dbus_rdata),
        .wdata   (e_data),
        .ld_data (ld_data),
        .st_data (st_data),
        .be      (be),
        .misal   (misal)
    );

    assign exc = v & e_mem & misal;
    assign mem1_stall = v & e_mem & ~exc & (state != DONE);
    assign cap = ~mem1_stall & ~wb_stall;
    assign ack = (state == REQ) & dbus_ack;

    // A kill outside REQ drops the entry at once; inside REQ the access must
    // still run to ack, so the kill is remembered and the data discarded then.
    always_comb begin
        state_nx = (csr_kill && state != REQ) ? IDLE :
                   ack ? ((kil || csr_kill) ? IDLE : DONE) :
                   cap ? ((ex_valid && ex_mem_en && !misaligned(ex_mem_size, ex_addr[1:0])) ? REQ : IDLE) :
                   state;
    end

    always_ff @(posedge clk_core) begin
        state <= reset ? IDLE : state_nx;
    end

    always_ff @(posedge clk_core) begin
        if (reset) begin
            v   <= 1'b0;
            kil <= 1'b0;
        end else begin
            v   <= ((csr_kill && state != REQ) || (ack && (kil || csr_kill))) ? 1'b0 : cap ? ex_valid : v;
            kil <= (state == REQ) && !dbus_ack && (kil || csr_kill);
        end
    end

    always_ff @(posedge clk_core) begin
        if (cap) begin
            e_mem   <= ex_mem_en;
            e_we    <= ex_mem_we;
            e_size  <= ex_mem_size;
            e_uns   <= ex_mem_unsigned;
            e_addr  <= ex_addr;
            e_data  <= ex_data;
            e_wb    <= ex_wb_reg;
            e_pc    <= ex_pc;
            e_flush <= ex_flush;
        end
        if (ack) ld_q <= ld_data;
    end

    assign dbus_req       = (state == REQ);
    assign dbus_we        = e_we;
    assign dbus_addr      = e_addr[31:2];
    assign dbus_be        = be;
    assign dbus_wdata     = st_data;
    assign mem1_busy      = (state == REQ);
    assign mem1_exc       = exc;
    assign mem1_exc_cause = exc ? (e_we ? SMISALIGNED : LMISALIGNED) : EC_NONE;
    assign mem1_valid_wb  = v & ~kil & (~e_mem | (~e_we & (state == DONE)));
    assign mem1_dout      = e_mem ? ld_q : e_data;
    assign mem1_flush     = e_flush;
    assign mem1_pc        = e_pc;
    assign mem1_wb_reg    = e_wb;
endmodule

// File: tb/tb_stage_mem1.sv
// tb_stage_mem1: directed bench for stage_mem1 with a transaction-level reference model
module tb_stage_mem1;
    import stage_mem1_pkg::*;

    logic        clk_core = 1'b0, reset = 1'b1;
    logic        ex_valid = 1'b0, ex_mem_en = 1'b0, ex_mem_we = 1'b0, ex_mem_unsigned = 1'b0, ex_flush = 1'b0;
    memsize_t    ex_mem_size = BYTE;
    logic [31:0] ex_addr = '0, ex_data = '0;
    logic [4:0]  ex_wb_reg = '0;
    logic [31:2] ex_pc = '0;
    logic        dbus_req, dbus_we;
    logic [31:2] dbus_addr;
    logic [3:0]  dbus_be;
    logic [31:0] dbus_wdata;
    logic        dbus_ack = 1'b0;
    logic [31:0] dbus_rdata = '0;
    logic        mem1_valid_wb, mem1_stall, mem1_busy, mem1_exc, mem1_flush;
    ecause_t     mem1_exc_cause;
    logic [31:2] mem1_pc;
    logic [4:0]  mem1_wb_reg;
    logic [31:0] mem1_dout;
    logic        wb_stall = 1'b0, csr_kill = 1'b0;

    int ntests = 0, nfail = 0;
    bit chk_en = 0;
    int lat = 0, age = 0;

    stage_mem1 dut (
        .clk_core(clk_core), .reset(reset),
        .ex_valid(ex_valid), .ex_mem_en(ex_mem_en), .ex_mem_we(ex_mem_we), .ex_mem_size(ex_mem_size),
        .ex_mem_unsigned(ex_mem_unsigned), .ex_addr(ex_addr), .ex_data(ex_data), .ex_wb_reg(ex_wb_reg),
        .ex_pc(ex_pc), .ex_flush(ex_flush),
        .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr), .dbus_be(dbus_be),
        .dbus_wdata(dbus_wdata), .dbus_ack(dbus_ack), .dbus_rdata(dbus_rdata),
        .mem1_valid_wb(mem1_valid_wb), .mem1_stall(mem1_stall), .mem1_busy(mem1_busy),
        .mem1_exc(mem1_exc), .mem1_exc_cause(mem1_exc_cause), .mem1_flush(mem1_flush),
        .mem1_pc(mem1_pc), .mem1_wb_reg(mem1_wb_reg), .mem1_dout(mem1_dout),
        .wb_stall(wb_stall), .csr_kill(csr_kill)
    );

    always #5 clk_core = ~clk_core;

    task automatic chk(string n, logic [31:0] a, logic [31:0] e);
        ntests++;
        if (a !== e) begin
            nfail++;
            $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
        end
    endtask

    task automatic chk1(string n, logic a, logic e);
        ntests++;
        if (a !== e) begin
            nfail++;
            $display("FAIL %s: got %b expected %b at %0t", n, a, e, $time);
        end
    endtask

    function automatic bit mis_f(int s, logic [1:0] a);
        return (s == 1 && a[0]) || (s == 2 && a != 2'd0);
    endfunction

    function automatic logic [31:0] be_f(int s, logic [1:0] a);
        return s == 0 ? 32'd1 << a : s == 1 ? (a[1] ? 32'hC : 32'h3) : 32'hF;
    endfunction

    function automatic logic [31:0] wdata_f(int s, logic [31:0] d);
        return s == 0 ? {24'b0, d[7:0]} * 32'h01010101 : s == 1 ? {16'b0, d[15:0]} * 32'h00010001 : d;
    endfunction

    function automatic logic [31:0] load_f(int s, bit uns, logic [1:0] a, logic [31:0] rd);
        logic [31:0] r;
        r = rd;
        if (s == 0) begin
            r = (rd >> (8 * int'(a))) & 32'hFF;
            if (!uns && r[7]) r = r | 32'hFFFFFF00;
        end else if (s == 1) begin
            r = (rd >> (16 * int'(a[1]))) & 32'hFFFF;
            if (!uns && r[15]) r = r | 32'hFFFF0000;
        end
        return r;
    endfunction

    // reference model: one held entry plus "bus outstanding" / "data ready" / "killed" flags
    bit          m_v = 0, m_mem = 0, m_we = 0, m_uns = 0, m_flush = 0, m_bus = 0, m_done = 0, m_kill = 0;
    int          m_size = 0;
    logic [31:0] m_addr = '0, m_data = '0, m_ld = '0;
    logic [4:0]  m_wb = '0;
    logic [31:2] m_pc = '0;

    always @(posedge clk_core) begin
        bit stall;
        stall = m_v && m_mem && !mis_f(m_size, m_addr[1:0]) && !m_done;
        if (reset) begin
            m_v = 0; m_bus = 0; m_done = 0; m_kill = 0;
        end else if (m_bus) begin
            if (dbus_ack) begin
                m_bus = 0;
                if (m_kill || csr_kill) begin
                    m_v = 0; m_kill = 0;
                end else begin
                    m_done = 1;
                    m_ld = load_f(m_size, m_uns, m_addr[1:0], dbus_rdata);
                end
            end else if (csr_kill) m_kill = 1;
        end else if (csr_kill) begin
            m_v = 0; m_done = 0;
        end else if (!stall && !wb_stall) begin
            m_v = ex_valid; m_mem = ex_mem_en; m_we = ex_mem_we; m_size = int'(ex_mem_size);
            m_uns = ex_mem_unsigned; m_addr = ex_addr; m_data = ex_data; m_wb = ex_wb_reg;
            m_pc = ex_pc; m_flush = ex_flush; m_done = 0;
            m_bus = ex_valid && ex_mem_en && !mis_f(m_size, ex_addr[1:0]);
        end
    end

    always @(negedge clk_core) begin
        if (chk_en) begin
            bit e_exc, e_wb;
            e_exc = m_v && m_mem && mis_f(m_size, m_addr[1:0]);
            e_wb  = m_v && !m_kill && (!m_mem || (!m_we && m_done));
            chk1("m_req", dbus_req, m_bus);
            chk1("m_busy", mem1_busy, m_bus);
            chk1("m_stall", mem1_stall, m_v && m_mem && !e_exc && !m_done);
            chk1("m_exc", mem1_exc, e_exc);
            chk1("m_valid_wb", mem1_valid_wb, e_wb);
            if (m_bus) begin
                chk1("m_we", dbus_we, m_we);
                chk("m_addr", {2'b0, dbus_addr}, {2'b0, m_addr[31:2]});
                chk("m_be", {28'b0, dbus_be}, be_f(m_size, m_addr[1:0]));
                chk("m_wdata", dbus_wdata, wdata_f(m_size, m_data));
            end
            if (e_wb) begin
                chk("m_dout", mem1_dout, m_mem ? m_ld : m_data);
                chk("m_wb_reg", {27'b0, mem1_wb_reg}, {27'b0, m_wb});
                chk("m_pc", {2'b0, mem1_pc}, {2'b0, m_pc});
                chk1("m_flush", mem1_flush, m_flush);
            end
            if (e_exc) chk("m_cause", {28'b0, mem1_exc_cause}, {28'b0, m_we ? SMISALIGNED : LMISALIGNED});
        end
    end

    // bus slave: ack arrives `lat` cycles after the request first appears
    always @(negedge clk_core) begin
        if (dbus_req) begin
            dbus_ack = (age == lat);
            age++;
        end else begin
            dbus_ack = 1'b0;
            age = 0;
        end
    end

    task automatic step();
        @(posedge clk_core);
        #1;
    endtask

    task automatic put(bit mem, bit we, memsize_t sz, bit uns, logic [31:0] a, logic [31:0] d, logic [4:0] r);
        ex_valid = 1'b1; ex_mem_en = mem; ex_mem_we = we; ex_mem_size = sz; ex_mem_unsigned = uns;
        ex_addr = a; ex_data = d; ex_wb_reg = r; ex_pc = a[31:2] ^ 30'h15; ex_flush = r[0];
    endtask

    task automatic idle();
        ex_valid = 1'b0; ex_mem_en = 1'b0; ex_mem_we = 1'b0;
    endtask

    initial begin
        logic [31:0] got[$];
        int nwb, first, i;
        // reset
        step(); step();
        reset = 1'b0;
        chk1("rst_req", dbus_req, 1'b0);
        chk1("rst_valid_wb", mem1_valid_wb, 1'b0);
        chk1("rst_exc", mem1_exc, 1'b0);
        chk1("rst_stall", mem1_stall, 1'b0);
        chk1("rst_busy", mem1_busy, 1'b0);
        chk_en = 1;
        // ALU op: one cycle
        put(0, 0, WORD, 0, 32'h0, 32'hDEADBEEF, 5'd5);
        step(); idle();
        chk1("alu_valid", mem1_valid_wb, 1'b1);
        chk("alu_dout", mem1_dout, 32'hDEADBEEF);
        chk1("alu_stall", mem1_stall, 1'b0);
        step();
        chk1("alu_gone", mem1_valid_wb, 1'b0);
        // signed byte load, ack 3 cycles after req
        lat = 3; dbus_rdata = 32'h80FFFFFF;
        put(1, 0, BYTE, 0, 32'h1003, 32'h0, 5'd9);
        step(); idle();
        chk1("ldb_req", dbus_req, 1'b1);
        chk("ldb_addr", {2'b0, dbus_addr}, 32'h400);
        chk("ldb_be", {28'b0, dbus_be}, 32'h8);
        nwb = 0; first = -1;
        for (int k = 1; k <= 8; k++) begin
            step();
            if (mem1_valid_wb) begin
                nwb++;
                if (first < 0) first = k;
                chk("ldb_dout", mem1_dout, 32'hFFFFFF80);
            end
        end
        chk("ldb_wb_count", nwb, 1);
        chk("ldb_wb_cycle", first, 4);
        // half store
        lat = 0;
        put(1, 1, HALF, 0, 32'h2002, 32'h1234ABCD, 5'd3);
        step(); idle();
        chk("sth_be", {28'b0, dbus_be}, 32'hC);
        chk("sth_wdata", dbus_wdata, 32'hABCDABCD);
        chk("sth_addr", {2'b0, dbus_addr}, 32'h800);
        chk1("sth_we", dbus_we, 1'b1);
        chk1("sth_valid", mem1_valid_wb, 1'b0);
        step();
        chk1("sth_done_valid", mem1_valid_wb, 1'b0);
        step();
        // misaligned load and store
        put(1, 0, WORD, 0, 32'h3001, 32'h0, 5'd4);
        step(); idle();
        chk1("mis_exc", mem1_exc, 1'b1);
        chk("mis_cause", {28'b0, mem1_exc_cause}, {28'b0, LMISALIGNED});
        chk1("mis_req", dbus_req, 1'b0);
        chk1("mis_valid", mem1_valid_wb, 1'b0);
        step();
        put(1, 1, HALF, 0, 32'h3003, 32'h0, 5'd4);
        step(); idle();
        chk("mis_scause", {28'b0, mem1_exc_cause}, {28'b0, SMISALIGNED});
        step();
        // unsigned half load, minimum latency
        put(1, 0, HALF, 1, 32'h1002, 32'h0, 5'd6);
        step(); idle();
        step();
        chk1("ldh_valid", mem1_valid_wb, 1'b1);
        chk("ldh_dout", mem1_dout, 32'h000080FF);
        step();
        // kill one cycle after req, ack two cycles after the kill
        lat = 3;
        put(1, 0, WORD, 0, 32'h1004, 32'h0, 5'd8);
        step(); idle();
        step();
        csr_kill = 1'b1;
        step();
        csr_kill = 1'b0;
        chk1("kill_req_held1", dbus_req, 1'b1);
        step();
        chk1("kill_req_held2", dbus_req, 1'b1);
        put(0, 0, WORD, 0, 32'h0, 32'h55, 5'd7);
        step();
        chk1("kill_req_off", dbus_req, 1'b0);
        chk1("kill_no_wb", mem1_valid_wb, 1'b0);
        step(); idle();
        chk1("kill_next_valid", mem1_valid_wb, 1'b1);
        chk("kill_next_dout", mem1_dout, 32'h55);
        step();
        // kill coincident with ack
        lat = 1;
        put(1, 0, WORD, 0, 32'h1008, 32'h0, 5'd10);
        step(); idle();
        step();
        csr_kill = 1'b1;
        step();
        csr_kill = 1'b0;
        chk1("kack_valid", mem1_valid_wb, 1'b0);
        chk1("kack_busy", mem1_busy, 1'b0);
        step();
        chk1("kack_valid2", mem1_valid_wb, 1'b0);
        // reset in the middle of a request
        lat = 5;
        put(1, 0, WORD, 0, 32'h100C, 32'h0, 5'd11);
        step(); idle();
        step();
        reset = 1'b1;
        step();
        chk1("rreq_req", dbus_req, 1'b0);
        chk1("rreq_valid", mem1_valid_wb, 1'b0);
        chk1("rreq_stall", mem1_stall, 1'b0);
        chk1("rreq_busy", mem1_busy, 1'b0);
        reset = 1'b0;
        step();
        // back-to-back ALU ops with a two-cycle writeback stall
        i = 0;
        for (int c = 0; c < 14; c++) begin
            bit adv;
            if (i < 6) put(0, 0, WORD, 0, 32'h0, 32'hA0 + i, 5'(i + 1));
            else idle();
            wb_stall = (c == 2 || c == 3);
            if (mem1_valid_wb && !wb_stall) got.push_back(mem1_dout);
            adv = !mem1_stall && !wb_stall;
            step();
            if (adv && i < 6) i++;
        end
        wb_stall = 1'b0;
        chk("stream_count", got.size(), 6);
        for (int k = 0; k < 6 && k < got.size(); k++) chk("stream_data", got[k], 32'hA0 + k);
        step();
        chk_en = 0;
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule

// File: doc/stage_mem1.md
STAGE_MEM1 -- requirements
Module: stage_mem1

Interface
REQ-001 SHALL have ports: clk_core in 1, single clock; reset in 1, synchronous active-high.
REQ-002 SHALL have execute inputs:
- ex_valid in 1
- ex_mem_en in 1
- ex_mem_we in 1
- ex_mem_size in memsize_t (BYTE/HALF/WORD)
- ex_mem_unsigned in 1
- ex_addr in 32
- ex_data in 32 (store data, or ALU result for non-memory ops)
- ex_wb_reg in 5
- ex_pc in [31:2]
- ex_flush in 1
REQ-003 SHALL have data bus ports:
- dbus_req out 1
- dbus_we out 1
- dbus_addr out [31:2]
- dbus_be out 4
- dbus_wdata out 32
- dbus_ack in 1
- dbus_rdata in 32
REQ-004 SHALL have writeback/CSR ports:
- mem1_valid_wb out 1
- mem1_stall out 1
- mem1_busy out 1
- mem1_exc out 1
- mem1_exc_cause out ecause_t
- mem1_flush out 1
- mem1_pc out [31:2]
- mem1_wb_reg out 5
- mem1_dout out 32
- wb_stall in 1
- csr_kill in 1

Function
REQ-005 SHALL capture ex_* into the stage register on any clk_core edge where mem1_stall=0 and wb_stall=0, otherwise hold.
REQ-006 A non-memory op SHALL take 1 cycle: mem1_valid_wb=1, mem1_dout=ex_data, mem1_stall=0.
REQ-007 Misalignment SHALL be: HALF with addr[0]=1, or WORD with addr[1:0]!=0.
REQ-008 A misaligned access SHALL raise mem1_exc=1 with cause LMISALIGNED (load) or SMISALIGNED (store), issue no bus request, and hold mem1_valid_wb=0.
REQ-009 The FSM SHALL have states IDLE, REQ and DONE.
- IDLE->REQ on the cycle after capture of an aligned memory op.
- REQ holds dbus_req=1 with stable addr/we/be/wdata until dbus_ack.
- REQ->DONE on ack.
- DONE->IDLE on the next capture.
REQ-010 mem1_stall SHALL equal valid & mem_en & ~exc & (state!=DONE).
REQ-011 mem1_busy SHALL equal (state==REQ).
REQ-012 Load data SHALL be registered on the ack cycle and visible on mem1_dout from the following cycle, giving a minimum load latency of 2 cycles with a same-cycle ack.
REQ-013 Load lane extraction SHALL use addr[1:0]: BYTE selects rdata[8*a+:8] and HALF selects rdata[16*a[1]+:16]; the result is zero-extended if ex_mem_unsigned, else sign-extended.
REQ-014 Stores SHALL replicate the byte or half across lanes in dbus_wdata.
- dbus_be: BYTE = 1<<a; HALF = 0011 or 1100; WORD = 1111.
- Stores SHALL write back nothing (mem1_valid_wb=0).
REQ-015 csr_kill SHALL invalidate the held entry on the next edge.
- If state==REQ, the transaction SHALL complete to ack (not abortable), its data SHALL be discarded, and the FSM returns to IDLE.
- If state!=REQ, the FSM SHALL return to IDLE immediately.
REQ-016 A simultaneous csr_kill and dbus_ack SHALL discard the data, go to IDLE, and produce no writeback.
REQ-017 wb_stall=1 SHALL freeze stage outputs but SHALL NOT deassert dbus_req in REQ; an ack during wb_stall SHALL still move to DONE.
REQ-018 mem1_flush, mem1_pc and mem1_wb_reg SHALL pass through from the captured entry unchanged.

Reset
REQ-019 Reset SHALL be synchronous, active-high, and dominate every other condition, including a mid-transaction REQ.
REQ-020 Reset SHALL force: state=IDLE, entry valid=0, dbus_req=0, mem1_valid_wb=0, mem1_exc=0, mem1_stall=0, mem1_busy=0.
REQ-021 Data-path registers (dout, pc, wb_reg, cause) SHALL NOT require reset.

Structure
REQ-022 memsize_t and the ecause_t values LMISALIGNED and SMISALIGNED SHALL live in the shared defines package.
REQ-023 Lane alignment (load extract/extend, store replicate/be) SHALL be one combinational sub-module, mem1_align.

Verification
REQ-024 Load with ex_addr=0x1003, BYTE signed, rdata=0x80FFFFFF, ack 3 cycles after req -> mem1_dout=0xFFFFFF80, one cycle of mem1_valid_wb.
REQ-025 Store with ex_addr=0x2002, HALF, ex_data=0x1234ABCD -> dbus_be=1100, dbus_wdata=0xABCDABCD, dbus_addr=0x800, mem1_valid_wb never asserted.
REQ-026 Load WORD at ex_addr=0x3001 -> mem1_exc=1 with cause LMISALIGNED, dbus_req never asserted.
REQ-027 csr_kill asserted 1 cycle after req, ack 2 cycles later -> dbus_req held to ack, no writeback, next op accepted the cycle after ack.
REQ-028 reset asserted during REQ -> dbus_req=0 and all valids 0 on the next edge.
REQ-029 Back-to-back ALU ops with wb_stall pulsed for 2 cycles -> no op lost or duplicated; mem1_dout matches each ex_data in order.
